mult16_seq: RTL and testbench
=============================

Name: mult16_seq

Overview:
- Sequential unsigned shift-and-add multiplier for the MIPS-16b datapath. Sits directly downstream of the adder chain built from the half/full adder primitives.
- Each cycle feeds one partial-product addition through a ripple adder and accumulates the 2*WIDTH-bit product.
- Used by the ALU for MULT-class instructions. Start/done handshake.

Parameters:
- WIDTH, 16, operand width in bits. Product width is 2*WIDTH.

Ports:
- clk  input  1  system clock, rising-edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request; sampled on a rising clk edge.
- a  input  WIDTH  multiplicand; captured when start is accepted.
- b  input  WIDTH  multiplier; captured when start is accepted.
- busy  output  1  high while a multiplication is in progress.
- done  output  1  one-cycle pulse when the product is valid.
- product  output  2*WIDTH  result register; holds its value until the next completion.
- hi_nz  output  1  high when product[2*WIDTH-1:WIDTH] != 0. Qualified with product.

Behaviour:
- Reset: asynchronous, active-high. Clears state to IDLE, and clears busy, done, product, hi_nz, the count and all internal registers. Takes effect immediately, including mid-operation. No partial result is ever published.
- States: IDLE, RUN, DONE (2-bit encoding).
- IDLE:
  - Edge with start=1: mcand<=a; acc<={WIDTH'b0, b}; count<=0; busy<=1; go to RUN.
  - Otherwise remain in IDLE.
- RUN, each edge:
  - If acc[0]=1: {c, sum} = acc[2*WIDTH-1:WIDTH] + mcand, giving a WIDTH+1-bit sum. Otherwise {c, sum} = {1'b0, acc[2*WIDTH-1:WIDTH]}.
  - acc <= {c, sum, acc[WIDTH-1:1]}, a logical right shift that keeps the carry.
  - count <= count+1.
  - On the edge where count=WIDTH-1: product<=new acc; hi_nz<=new acc high half nonzero; busy<=0; done<=1; go to DONE.
- DONE:
  - Lasts exactly one cycle; done drops on the next edge.
  - start=1 on that edge is accepted exactly as in IDLE (back-to-back issue). Otherwise go to IDLE.
- Latency: start sampled at edge E. done and the new product are visible after edge E+WIDTH (E+16 by default). Throughput is one multiply per WIDTH+1 cycles.
- start while busy=1 is ignored. The operands of the in-flight operation are unaffected.
- a and b are don't-care except on the accepting edge.
- product and hi_nz change only on the completion edge or on reset.
- Arithmetic: unsigned only. Overflow is impossible because the 2*WIDTH-bit product is exact. The carry c must be retained; dropping it is a bug (see the 0xFFFF*0xFFFF case).
- count width is clog2(WIDTH)+1.

Decomposition:
- Shared package mult_pkg:
  - State encoding constants: IDLE=2'd0, RUN=2'd1, DONE=2'd2.
  - WIDTH default.
  - Count-width constant.
- One sub-module, add_ripple: a WIDTH-bit ripple-carry adder built from full adders, each composed of two half adders and an OR. It has inputs x, y and outputs s[WIDTH-1:0] and cout. It is purely combinational and instantiated once for the high-half accumulate.
- Control FSM and registers stay in mult16_seq.

Test Plan:
- Reset asserted, then released; start with a=0x0003, b=0x0005 at edge 1. Expect busy=1 for edges 1..16, done=1 exactly one cycle after edge 16, product=0x0000000F, hi_nz=0.
- a=0xFFFF, b=0xFFFF. Expect product=0xFFFE0001, hi_nz=1. This checks carry retention.
- a=0x0000, b=0x1234, then a=0x1234, b=0x0001. Expect product=0x00000000, then 0x00001234. product holds 0 between the two operations.
- Start a=0x0002, b=0x0003; re-pulse start with a=0x00FF, b=0x00FF at edge 5. Expect the second start ignored, product=0x00000006, and busy timing unchanged.
- Start a=0x1234, b=0x5678; assert rst asynchronously mid-cycle at edge 8. Expect busy, done, product and hi_nz to read 0 immediately, with no done pulse after release.
- Back-to-back: start held high through the DONE cycle with a=0x0100, b=0x0100 following a=7, b=9. Expect product=0x0000003F, then 0x00010000 with hi_nz=1 exactly 17 cycles later.

Source files
------------

// File: rtl/mult_pkg.sv
// Shared constants for the sequential shift-and-add multiplier.
//   WIDTH_DEF : default operand width
//   CNT_W     : iteration counter width for the default operand width
//   state_e   : control FSM encoding (IDLE/RUN/DONE)
package mult_pkg;

  localparam int unsigned WIDTH_DEF = 16;
  localparam int unsigned CNT_W     = $clog2(WIDTH_DEF) + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/add_ripple.sv
// WIDTH-bit ripple-carry adder built from full adders (two half adders + OR).
// Ports:
//   x, y : addends
//   s    : WIDTH-bit sum
//   cout : carry out of the MSB
module add_ripple
  import mult_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF
) (
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  output logic [WIDTH-1:0] s,
  output logic             cout
);

  logic [WIDTH:0]   c;
  logic [WIDTH-1:0] h1_s;
  logic [WIDTH-1:0] h1_c;
  logic [WIDTH-1:0] h2_c;

  assign c[0] = 1'b0;

  // One full adder per bit: half adder on x/y, half adder with carry-in, OR of carries.
  for (genvar i = 0; i < WIDTH; i++) begin : g_fa
    assign h1_s[i]  = x[i] ^ y[i];
    assign h1_c[i]  = x[i] & y[i];
    assign s[i]     = h1_s[i] ^ c[i];
    assign h2_c[i]  = h1_s[i] & c[i];
    assign c[i+1]   = h1_c[i] | h2_c[i];
  end

  assign cout = c[WIDTH];

endmodule

// File: rtl/mult16_seq.sv
// Sequential unsigned shift-and-add multiplier, one partial product per cycle.
// Ports:
//   clk, rst : clock (rising edge), asynchronous active-high reset
//   start    : request, accepted in IDLE or DONE
//   a, b     : multiplicand / multiplier, captured on the accepting edge
//   busy     : multiplication in progress
//   done     : one-cycle pulse when product is updated
//   product  : 2*WIDTH-bit result, held until the next completion
//   hi_nz    : product high half is nonzero
module mult16_seq
  import mult_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product,
  output logic               hi_nz
);

  localparam int unsigned CW = $clog2(WIDTH) + 1;

  state_e             state_q;
  logic [WIDTH-1:0]   mcand_q;
  logic [2*WIDTH-1:0] acc_q;
  logic [2*WIDTH-1:0] acc_d;
  logic [CW-1:0]      count_q;
  logic               busy_q;
  logic               done_q;
  logic [2*WIDTH-1:0] product_q;
  logic               hi_nz_q;

  logic [WIDTH-1:0]   addend;
  logic [WIDTH-1:0]   sum;
  logic               carry;
  logic               last_c;

  // Partial product is the multiplicand when the current multiplier LSB is set.
  assign addend = acc_q[0] ? mcand_q : '0;

  add_ripple #(.WIDTH(WIDTH)) u_add (
    .x    (acc_q[2*WIDTH-1:WIDTH]),
    .y    (addend),
    .s    (sum),
    .cout (carry)
  );

  // Shift right while keeping the adder carry as the new MSB.
  assign acc_d  = {carry, sum, acc_q[WIDTH-1:1]};
  assign last_c = (count_q == CW'(WIDTH - 1));

  // Control FSM and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      mcand_q   <= '0;
      acc_q     <= '0;
      count_q   <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      product_q <= '0;
      hi_nz_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE, DONE: begin
          if (start) begin
            mcand_q <= a;
            acc_q   <= {WIDTH'(0), b};
            count_q <= '0;
            busy_q  <= 1'b1;
            state_q <= RUN;
          end else begin
            state_q <= IDLE;
          end
        end
        RUN: begin
          acc_q   <= acc_d;
          count_q <= count_q + CW'(1);
          if (last_c) begin
            product_q <= acc_d;
            hi_nz_q   <= |acc_d[2*WIDTH-1:WIDTH];
            busy_q    <= 1'b0;
            done_q    <= 1'b1;
            state_q   <= DONE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign product = product_q;
  assign hi_nz   = hi_nz_q;

endmodule

// File: tb/tb_mult16_seq.sv
// Directed self-checking bench for mult16_seq.
module tb_mult16_seq;

  logic        clk;
  logic        rst;
  logic        start;
  logic [15:0] a;
  logic [15:0] b;
  logic        busy;
  logic        done;
  logic [31:0] product;
  logic        hi_nz;

  int n_checks;
  int n_fail;
  logic [31:0] last_p;

  mult16_seq dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .a       (a),
    .b       (b),
    .busy    (busy),
    .done    (done),
    .product (product),
    .hi_nz   (hi_nz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Wait for done with a cycle budget; returns edges waited (budget+1 on timeout).
  task automatic wait_done(input string tag, output int cyc);
    cyc = 0;
    while (!done && cyc < 40) begin
      tick();
      cyc++;
      if (!done) check({tag, "_busy_run"}, 64'(busy), 64'd1);
    end
    if (!done) begin
      check({tag, "_timeout"}, 64'(done), 64'd1);
      cyc = 41;
    end
  endtask

  // Full operation: accept edge, run, completion checks, done drops.
  task automatic do_mul(input string tag, input logic [15:0] av, input logic [15:0] bv,
                        input logic [31:0] exp_p, input logic exp_hi);
    int cyc;
    a = av;
    b = bv;
    start = 1'b1;
    tick();
    start = 1'b0;
    a = 16'hDEAD;
    b = 16'hBEEF;
    check({tag, "_busy_start"}, 64'(busy), 64'd1);
    for (int i = 0; i < 7; i++) tick();
    check({tag, "_hold_mid"}, 64'(product), 64'(last_p));
    cyc = 7;
    begin
      int rest;
      wait_done(tag, rest);
      cyc += rest;
    end
    check({tag, "_latency"}, 64'(cyc), 64'd16);
    check({tag, "_product"}, 64'(product), 64'(exp_p));
    check({tag, "_hi_nz"}, 64'(hi_nz), 64'(exp_hi));
    check({tag, "_busy_done"}, 64'(busy), 64'd0);
    tick();
    check({tag, "_done_drop"}, 64'(done), 64'd0);
    check({tag, "_product_hold"}, 64'(product), 64'(exp_p));
    last_p = exp_p;
  endtask

  initial begin
    int cyc;
    int pulses;
    n_checks = 0;
    n_fail   = 0;
    last_p   = 32'h0;
    rst   = 1'b1;
    start = 1'b0;
    a     = 16'h0;
    b     = 16'h0;
    tick();
    tick();
    check("rst_busy",    64'(busy),    64'd0);
    check("rst_done",    64'(done),    64'd0);
    check("rst_product", 64'(product), 64'd0);
    check("rst_hi_nz",   64'(hi_nz),   64'd0);
    #2 rst = 1'b0;
    tick();

    do_mul("m3x5",    16'h0003, 16'h0005, 32'h0000000F, 1'b0);
    do_mul("mffff",   16'hFFFF, 16'hFFFF, 32'hFFFE0001, 1'b1);
    do_mul("mzero",   16'h0000, 16'h1234, 32'h00000000, 1'b0);
    do_mul("mone",    16'h1234, 16'h0001, 32'h00001234, 1'b0);

    // Start pulse while busy must be ignored.
    a = 16'h0002;
    b = 16'h0003;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    a = 16'h00FF;
    b = 16'h00FF;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("ign_busy", 64'(busy), 64'd1);
    wait_done("ign", cyc);
    check("ign_latency", 64'(cyc + 4), 64'd16);
    check("ign_product", 64'(product), 64'h6);
    check("ign_hi_nz",   64'(hi_nz),   64'd0);
    tick();
    tick();
    check("ign_idle_busy", 64'(busy), 64'd0);
    last_p = 32'h6;

    // Asynchronous reset mid-operation.
    a = 16'h1234;
    b = 16'h5678;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 7; i++) tick();
    #2 rst = 1'b1;
    #1;
    check("arst_busy",    64'(busy),    64'd0);
    check("arst_done",    64'(done),    64'd0);
    check("arst_product", 64'(product), 64'd0);
    check("arst_hi_nz",   64'(hi_nz),   64'd0);
    tick();
    #2 rst = 1'b0;
    pulses = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (done || busy) pulses++;
    end
    check("arst_no_done", 64'(pulses), 64'd0);
    last_p = 32'h0;

    // Back-to-back: start held through the DONE cycle.
    a = 16'h0007;
    b = 16'h0009;
    start = 1'b1;
    tick();
    a = 16'h0100;
    b = 16'h0100;
    wait_done("b2b1", cyc);
    check("b2b1_latency", 64'(cyc), 64'd16);
    check("b2b1_product", 64'(product), 64'h3F);
    check("b2b1_hi_nz",   64'(hi_nz),   64'd0);
    tick();
    start = 1'b0;
    check("b2b_busy_again", 64'(busy), 64'd1);
    check("b2b_done_drop",  64'(done), 64'd0);
    check("b2b_hold",       64'(product), 64'h3F);
    wait_done("b2b2", cyc);
    check("b2b2_latency", 64'(cyc + 1), 64'd17);
    check("b2b2_product", 64'(product), 64'h00010000);
    check("b2b2_hi_nz",   64'(hi_nz),   64'd1);
    tick();
    check("b2b2_done_drop", 64'(done), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
